// File: rtl/data_syn_filt.sv
// Multi-channel level synchronizer: per-channel flop chain, stability filter and
// registered one-cycle rise/fall pulses. Single clock, synchronous active-high reset.
module data_syn_filt #(
    parameter int unsigned      WIDTH    = 4,
    parameter int unsigned      STAGES   = 2,
    parameter int unsigned      FILT_CNT = 4,
    parameter logic [WIDTH-1:0] INIT     = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             chg_o
);

    localparam int unsigned     CntW   = (FILT_CNT > 1) ? $clog2(FILT_CNT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(FILT_CNT - 1);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];
    logic [CntW-1:0]  cnt_q  [WIDTH];
    logic [CntW-1:0]  cnt_d  [WIDTH];
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] sync_s;

    always_comb begin
        sync_d[0] = data_i;
        for (int unsigned k = 1; k < STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign sync_s = sync_q[STAGES-1];

    // A differing value must be seen on FILT_CNT consecutive edges before it commits;
    // any return to the committed level clears the run.
    always_comb begin
        data_d = data_q;
        rise_d = '0;
        fall_d = '0;
        for (int unsigned n = 0; n < WIDTH; n++) begin
            cnt_d[n] = '0;
            if (sync_s[n] != data_q[n]) begin
                if (cnt_q[n] == CntMax) begin
                    data_d[n] = sync_s[n];
                    rise_d[n] = sync_s[n];
                    fall_d[n] = ~sync_s[n];
                end else begin
                    cnt_d[n] = cnt_q[n] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                sync_q[k] <= INIT;
            end
            for (int unsigned n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= '0;
            end
            data_q <= INIT;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int unsigned n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
            data_q <= data_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign data_o = data_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign chg_o  = |(rise_q | fall_q);

endmodule

// File: tb/tb_data_syn_filt.sv
// Bench for data_syn_filt: constant vector tables, directed corner sequences and a
// randomized run checked against a run-length reference model.
module tb_data_syn_filt;

    localparam int unsigned W    = 4;
    localparam int unsigned A_ST = 2;
    localparam int unsigned A_FC = 4;

    typedef struct {
        logic         rst;
        logic [W-1:0] din;
        logic [W-1:0] exp_d;
        logic [W-1:0] exp_r;
        logic [W-1:0] exp_f;
        logic         exp_c;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a, rst_b;
    logic [W-1:0] din_a, din_b;
    logic [W-1:0] dout_a, rise_a, fall_a;
    logic [W-1:0] dout_b, rise_b, fall_b;
    logic         chg_a, chg_b;

    data_syn_filt #(
        .WIDTH    (W),
        .STAGES   (A_ST),
        .FILT_CNT (A_FC),
        .INIT     (4'h0)
    ) u_dut_a (
        .clk_i  (clk),
        .rst_i  (rst_a),
        .data_i (din_a),
        .data_o (dout_a),
        .rise_o (rise_a),
        .fall_o (fall_a),
        .chg_o  (chg_a)
    );

    data_syn_filt #(
        .WIDTH    (W),
        .STAGES   (3),
        .FILT_CNT (1),
        .INIT     (4'hA)
    ) u_dut_b (
        .clk_i  (clk),
        .rst_i  (rst_b),
        .data_i (din_b),
        .data_o (dout_b),
        .rise_o (rise_b),
        .fall_o (fall_b),
        .chg_o  (chg_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: input seen by the filter is the input from STAGES edges earlier; a level
    // commits once it has differed from the output on FILT_CNT consecutive edges.
    logic [W-1:0] m_pipe[$];
    logic [W-1:0] m_data, m_rise, m_fall;
    int           m_run[W];

    task automatic model_edge(input logic rst, input logic [W-1:0] din);
        logic [W-1:0] s;
        m_rise = '0;
        m_fall = '0;
        if (rst) begin
            m_pipe.delete();
            for (int k = 0; k < int'(A_ST); k++) m_pipe.push_back(4'h0);
            m_data = 4'h0;
            for (int n = 0; n < int'(W); n++) m_run[n] = 0;
        end else begin
            s = m_pipe.pop_front();
            m_pipe.push_back(din);
            for (int n = 0; n < int'(W); n++) begin
                if (s[n] == m_data[n]) begin
                    m_run[n] = 0;
                end else begin
                    m_run[n]++;
                    if (m_run[n] == int'(A_FC)) begin
                        m_data[n] = s[n];
                        m_rise[n] = s[n];
                        m_fall[n] = ~s[n];
                        m_run[n]  = 0;
                    end
                end
            end
        end
    endtask

    task automatic step_a(input logic rst, input logic [W-1:0] din);
        @(negedge clk);
        rst_a = rst;
        din_a = din;
        @(posedge clk);
        model_edge(rst, din);
        #1;
        check("mdl_data", dout_a, m_data);
        check("mdl_rise", rise_a, m_rise);
        check("mdl_fall", fall_a, m_fall);
        check("mdl_chg", {3'b0, chg_a}, {3'b0, |(m_rise | m_fall)});
    endtask

    task automatic step_b(input logic rst, input logic [W-1:0] din);
        @(negedge clk);
        rst_b = rst;
        din_b = din;
        @(posedge clk);
        #1;
    endtask

    vec_t tab_a[$];
    vec_t tab_b[$];
    logic [W-1:0] rnd_din;
    int           fall_cnt;

    initial begin
        rst_a = 1'b1;
        din_a = '0;
        rst_b = 1'b1;
        din_b = '0;

        // Reset with inputs high, then first commit 6 edges after release
        for (int i = 0; i < 3; i++) tab_a.push_back('{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0});
        for (int i = 1; i <= 5; i++) tab_a.push_back('{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0});
        tab_a.push_back('{1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1});
        tab_a.push_back('{1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0});

        // STAGES=3, FILT_CNT=1, INIT=A: commit at edge 4
        for (int i = 0; i < 2; i++) tab_b.push_back('{1'b1, 4'h5, 4'hA, 4'h0, 4'h0, 1'b0});
        for (int i = 1; i <= 3; i++) tab_b.push_back('{1'b0, 4'h5, 4'hA, 4'h0, 4'h0, 1'b0});
        tab_b.push_back('{1'b0, 4'h5, 4'h5, 4'h5, 4'hA, 1'b1});
        tab_b.push_back('{1'b0, 4'h5, 4'h5, 4'h0, 4'h0, 1'b0});

        foreach (tab_a[i]) begin
            step_a(tab_a[i].rst, tab_a[i].din);
            check("t1_data", dout_a, tab_a[i].exp_d);
            check("t1_rise", rise_a, tab_a[i].exp_r);
            check("t1_fall", fall_a, tab_a[i].exp_f);
            check("t1_chg", {3'b0, chg_a}, {3'b0, tab_a[i].exp_c});
        end

        // Glitch of 3 cycles is discarded
        repeat (8) step_a(1'b0, 4'h0);
        check("t2_base", dout_a, 4'h0);
        for (int i = 1; i <= 10; i++) begin
            step_a(1'b0, (i <= 3) ? 4'h1 : 4'h0);
            check("t2_short", {1'b0, dout_a[0], rise_a[0], fall_a[0]}, 4'h0);
        end
        // 4-cycle pulse commits at edge 6, returns at edge 10
        for (int i = 1; i <= 12; i++) begin
            step_a(1'b0, (i <= 4) ? 4'h1 : 4'h0);
            check("t2_d0", {3'b0, dout_a[0]}, (i >= 6 && i < 10) ? 4'h1 : 4'h0);
            check("t2_r0", {3'b0, rise_a[0]}, (i == 6) ? 4'h1 : 4'h0);
            check("t2_f0", {3'b0, fall_a[0]}, (i == 10) ? 4'h1 : 4'h0);
        end

        // Toggle every cycle never commits
        for (int i = 0; i < 50; i++) begin
            step_a(1'b0, (i % 2 == 1) ? 4'h2 : 4'h0);
            check("t3_tog", {1'b0, dout_a[1], rise_a[1], fall_a[1]}, 4'h0);
        end
        repeat (6) step_a(1'b0, 4'h0);

        // Independent channels with staggered rises
        for (int i = 1; i <= 10; i++) begin
            step_a(1'b0, (i >= 3) ? 4'hA : 4'h2);
            check("t4_rise", rise_a, (i == 6) ? 4'h2 : (i == 8) ? 4'h8 : 4'h0);
            check("t4_chg", {3'b0, chg_a}, (i == 6 || i == 8) ? 4'h1 : 4'h0);
        end
        repeat (8) step_a(1'b0, 4'hE);
        check("t4_set2", dout_a, 4'hE);
        fall_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            step_a(1'b0, 4'hA);
            if (fall_a[2]) fall_cnt++;
            check("t4_fall", fall_a, (i == 6) ? 4'h4 : 4'h0);
        end
        check("t4_fall_cnt", fall_cnt[W-1:0], 4'h1);

        // Reset while a change is pending with a partial count
        repeat (8) step_a(1'b0, 4'h0);
        for (int i = 1; i <= 4; i++) step_a(1'b0, 4'h1);
        step_a(1'b1, 4'h1);
        check("t5_rst_d", dout_a, 4'h0);
        check("t5_rst_p", rise_a | fall_a, 4'h0);
        for (int i = 1; i <= 7; i++) begin
            step_a(1'b0, 4'h1);
            check("t5_data", dout_a, (i >= 6) ? 4'h1 : 4'h0);
            check("t5_rise", rise_a, (i == 6) ? 4'h1 : 4'h0);
        end

        // Random levels with occasional glitches and rare resets
        rnd_din = 4'h0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0) rnd_din = rnd_din ^ 4'($urandom_range(1, 15));
            step_a(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, rnd_din);
        end

        foreach (tab_b[i]) begin
            step_b(tab_b[i].rst, tab_b[i].din);
            check("t6_data", dout_b, tab_b[i].exp_d);
            check("t6_rise", rise_b, tab_b[i].exp_r);
            check("t6_fall", fall_b, tab_b[i].exp_f);
            check("t6_chg", {3'b0, chg_b}, {3'b0, tab_b[i].exp_c});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
